// File: rtl/fifo_wr_packer.sv
// Write-side ingress for the asynchronous FIFO: packs RATIO narrow beats into one
// FIFO word behind a one-entry output slot, with flush/last padding and write status.
module fifo_wr_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [IN_WIDTH-1:0]           s_data,
    input  logic                          s_last,
    input  logic                          flush,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [IN_WIDTH*RATIO-1:0]     fifo_din,
    output logic [CNT_WIDTH-1:0]          words_written,
    output logic                          pkt_done
);

    localparam int DW    = IN_WIDTH * RATIO;
    localparam int ACC_W = (RATIO - 1) * IN_WIDTH;
    localparam int IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    logic [ACC_W-1:0]     acc_r;
    logic [IDX_W-1:0]     idx_r;
    logic [DW-1:0]        out_word_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic                 flush_pend_r;
    logic [CNT_WIDTH-1:0] words_written_r;
    logic                 pkt_done_r;

    logic                 wr_en_s;
    logic                 slot_free_s;
    logic                 accept_s;
    logic                 flush_req_s;
    logic                 complete_s;
    logic                 flush_emit_s;
    logic                 flush_hold_s;
    logic [DW-1:0]        acc_ext_s;
    logic [DW-1:0]        beat_word_s;

    // Slot drains whenever it holds a word and the FIFO has room; that same cycle frees it.
    assign wr_en_s      = out_valid_r & ~fifo_full;
    assign slot_free_s  = ~out_valid_r | ~fifo_full;
    assign accept_s     = s_valid & slot_free_s;
    assign flush_req_s  = flush | flush_pend_r;
    assign complete_s   = accept_s & ((idx_r == LAST_IDX) | s_last | flush_req_s);
    assign flush_emit_s = ~accept_s & flush_req_s & (idx_r != IDX_ZERO) & slot_free_s;
    assign flush_hold_s = ~accept_s & flush_req_s & (idx_r != IDX_ZERO) & ~slot_free_s;
    assign acc_ext_s    = {{IN_WIDTH{1'b0}}, acc_r};

    // Accumulator with the incoming beat dropped into lane idx; lanes above idx stay zero.
    always_comb begin
        beat_word_s = acc_ext_s;
        for (int k = 0; k < RATIO; k++) begin
            beat_word_s[k*IN_WIDTH +: IN_WIDTH] = (IDX_W'(k) == idx_r) ? s_data
                                                 : acc_ext_s[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    // Accumulate stage, output slot and pending-flush tracking.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            acc_r        <= {ACC_W{1'b0}};
            idx_r        <= IDX_ZERO;
            out_word_r   <= {DW{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            flush_pend_r <= 1'b0;
        end else if (complete_s) begin
            out_word_r   <= beat_word_s;
            out_valid_r  <= 1'b1;
            out_last_r   <= s_last | flush_req_s;
            idx_r        <= IDX_ZERO;
            acc_r        <= {ACC_W{1'b0}};
            flush_pend_r <= 1'b0;
        end else if (flush_emit_s) begin
            out_word_r   <= acc_ext_s;
            out_valid_r  <= 1'b1;
            out_last_r   <= 1'b1;
            idx_r        <= IDX_ZERO;
            acc_r        <= {ACC_W{1'b0}};
            flush_pend_r <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r & ~wr_en_s;
            flush_pend_r <= flush_hold_s;
            if (accept_s) begin
                acc_r <= beat_word_s[ACC_W-1:0];
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                acc_r <= acc_r;
                idx_r <= idx_r;
            end
        end
    end

    // Write counter (wraps naturally) and packet-done pulse for status logic.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            words_written_r <= {CNT_WIDTH{1'b0}};
            pkt_done_r      <= 1'b0;
        end else begin
            words_written_r <= words_written_r + CNT_WIDTH'(wr_en_s);
            pkt_done_r      <= wr_en_s & out_last_r;
        end
    end

    assign s_ready       = slot_free_s;
    assign fifo_wr_en    = wr_en_s;
    assign fifo_din      = out_word_r;
    assign words_written = words_written_r;
    assign pkt_done      = pkt_done_r;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench for fifo_wr_packer: queue-based packet model feeds a scoreboard
// that a separate monitor drains on every FIFO write.
module tb_fifo_wr_packer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int CW = 8;   // narrow counter so the wrap is reached quickly
    localparam int DW = IW * R;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [IW-1:0] s_data = 8'h00;
    logic          s_last = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_full = 1'b0;
    logic          s_ready;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic [CW-1:0] words_written;
    logic          pkt_done;

    fifo_wr_packer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(CW)) dut (
        .wr_clk(wr_clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .flush(flush), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .words_written(words_written), .pkt_done(pkt_done)
    );

    always #5 wr_clk = ~wr_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW:0]   exp_q[$];   // {last, word}
    logic [IW-1:0] part_q[$];
    bit            m_pend;
    bit            m_acc;
    bit            m_fl;

    function automatic logic [DW-1:0] pack_word(input logic [IW-1:0] q[$]);
        logic [DW-1:0] w = '0;
        for (int k = 0; k < q.size(); k++) w = w | (DW'(q[k]) << (IW * k));
        return w;
    endfunction

    task automatic emit(input bit last);
        exp_q.push_back({last, pack_word(part_q)});
        part_q.delete();
    endtask

    always @(negedge wr_clk) begin : model
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            m_pend = 1'b0;
        end else begin
            m_acc = s_valid && s_ready;
            m_fl  = flush || m_pend;
            if (m_acc) begin
                part_q.push_back(s_data);
                if (part_q.size() == R || s_last || m_fl) begin
                    emit(s_last || m_fl);
                    m_pend = 1'b0;
                end
            end else if (m_fl && part_q.size() > 0) begin
                if (s_ready) begin
                    emit(1'b1);
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end else begin
                m_pend = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [CW-1:0] exp_cnt;
    logic          exp_pkt;
    logic [DW:0]   e;
    logic [DW-1:0] prev_din;
    bit            hold_prev;
    int            cyc = 0;
    int            last_wr = 0;
    bit            gap_arm = 1'b0;
    int            gap_min = 1000;
    int            gap_max = 0;
    int            wr_seen = 0;

    always @(negedge wr_clk) begin : monitor
        cyc++;
        if (rst) begin
            exp_cnt   = '0;
            exp_pkt   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            check("words_written", words_written, exp_cnt);
            check("pkt_done", pkt_done, exp_pkt);
            exp_pkt = 1'b0;
            if (fifo_full) check("wr_en_while_full", fifo_wr_en, 1'b0);
            if (hold_prev) check("din_stable", fifo_din, prev_din);
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: din 0x%0h, no word expected", fifo_din);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_din", fifo_din, e[DW-1:0]);
                    exp_pkt = e[DW];
                end
                exp_cnt = exp_cnt + 1'b1;
                wr_seen++;
                if (gap_arm) begin
                    if (cyc - last_wr < gap_min) gap_min = cyc - last_wr;
                    if (cyc - last_wr > gap_max) gap_max = cyc - last_wr;
                end
                gap_arm = 1'b1;
                last_wr = cyc;
            end
            hold_prev = !s_ready;
            prev_din  = fifo_din;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] d, input bit last, input bit fl);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        flush   = fl;
        for (int t = 0; ; t++) begin
            @(negedge wr_clk);
            if (s_ready) break;
            if (t > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: s_ready stuck at 0, expected 1");
                break;
            end
        end
        @(posedge wr_clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        flush   = 1'b0;
        s_data  = IW'($urandom);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    int w0;

    initial begin
        // T1: reset, including an asynchronous reset in the middle of a packet
        #2;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_din", fifo_din, 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("midrst_wr_en", fifo_wr_en, 1'b0);
        check("midrst_s_ready", s_ready, 1'b1);
        check("midrst_din", fifo_din, 32'h0);
        check("midrst_count", words_written, 8'h00);
        check("midrst_pkt", pkt_done, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // T2: full word, one cycle latency, then count
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        check("t2_wr_en", fifo_wr_en, 1'b1);
        check("t2_din", fifo_din, 32'h44332211);
        tick();
        check("t2_count", words_written, 8'd1);

        // T3: partial packet via s_last
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b1, 1'b0);
        check("t3_wr_en", fifo_wr_en, 1'b1);
        check("t3_din", fifo_din, 32'h0000BBAA);
        tick();
        check("t3_pkt_done", pkt_done, 1'b1);
        check("t3_count", words_written, 8'd2);

        // T4: back-pressure with a loaded slot
        fifo_full = 1'b1;
        for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h05;
        for (int i = 0; i < 3; i++) begin
            check("t4_s_ready", s_ready, 1'b0);
            check("t4_wr_en", fifo_wr_en, 1'b0);
            check("t4_din", fifo_din, 32'h04030201);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        check("t4_release_wr_en", fifo_wr_en, 1'b1);
        check("t4_release_ready", s_ready, 1'b1);
        for (int i = 5; i <= 8; i++) send(IW'(i), 1'b0, 1'b0);
        repeat (2) tick();

        // T5: 64 back-to-back beats -> 16 evenly spaced writes
        gap_arm = 1'b0;
        gap_min = 1000;
        gap_max = 0;
        w0 = wr_seen;
        for (int i = 0; i < 64; i++) send(IW'(8'h40 + i), 1'b0, 1'b0);
        repeat (3) tick();
        check("t5_writes", 64'(wr_seen - w0), 64'd16);
        check("t5_gap_min", 64'(gap_min), 64'd4);
        check("t5_gap_max", 64'(gap_max), 64'd4);

        // T6: flush at idx 3 pads; flush at idx 0 does nothing
        send(8'hC1, 1'b0, 1'b0);
        send(8'hC2, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b0);
        pulse_flush();
        check("t6_wr_en", fifo_wr_en, 1'b1);
        check("t6_din", fifo_din, 32'h00C3C2C1);
        tick();
        check("t6_pkt_done", pkt_done, 1'b1);
        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            check("t6_idle_flush", fifo_wr_en, 1'b0);
            tick();
        end

        // Random traffic: long enough to wrap the write counter several times
        for (int i = 0; i < 3000; i++) begin
            s_valid   = ($urandom_range(0, 9) < 7);
            s_data    = IW'($urandom);
            s_last    = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            fifo_full = ($urandom_range(0, 9) < 3);
            tick();
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        fifo_full = 1'b0;
        pulse_flush();
        repeat (10) tick();
        check("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        check("drain_partial", 64'(part_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
